// File: rtl/fft_pkg.sv
// Shared definitions for the FFT complex-multiplier controller.
//   N_DATA  : sample/twiddle width, sign-magnitude (bit 7 sign, bits 6:0 Q7 magnitude)
//   MUL_LAT : edges from mul_en sampled high until the multiplier's RE/IM are stable
//   TAG_W   : opaque request tag width
//   CNT_W   : width of the shared drain/wait counter (must hold MUL_LAT)
//   W8_TW   : twiddle ROM, W8^k packed as {re, im}
package fft_pkg;

    localparam int N_DATA  = 8;
    localparam int MUL_LAT = 13;
    localparam int TAG_W   = 3;
    localparam int CNT_W   = $clog2(MUL_LAT + 1);

    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } cmul_state_t;

    localparam logic [2*N_DATA-1:0] W8_TW [4] = '{
        16'h7F00,   // k=0:  1
        16'h5BDB,   // k=1:  0.707 - j0.707
        16'h00FF,   // k=2: -j
        16'hDBDB    // k=3: -0.707 - j0.707
    };

endpackage

// File: rtl/fft_cmul_ctrl_if.sv
// Request and result channels of the complex-multiplier controller.
//   req_* : sample {re, im}, twiddle index, tag from the requester
//   res_* : multiplier RE/IM and the matching tag back to the consumer
//   slave  modport : the controller
//   master modport : the requester/consumer
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Once valid is raised the source holds it and its payload
// stable until that edge; ready may be asserted with or without valid and
// never depends on valid in the same cycle.
interface fft_cmul_ctrl_if #(
    parameter int N  = 8,
    parameter int TW = 3
);
    logic          req_valid;
    logic          req_ready;
    logic [N-1:0]  req_re;
    logic [N-1:0]  req_im;
    logic [1:0]    req_tw;
    logic [TW-1:0] req_tag;

    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_re;
    logic [N-1:0]  res_im;
    logic [TW-1:0] res_tag;

    modport slave (
        input  req_valid, req_re, req_im, req_tw, req_tag, res_ready,
        output req_ready, res_valid, res_re, res_im, res_tag
    );

    modport master (
        output req_valid, req_re, req_im, req_tw, req_tag, res_ready,
        input  req_ready, res_valid, res_re, res_im, res_tag
    );
endinterface

// File: rtl/tw_rom.sv
// Combinational twiddle lookup: index k -> W8^k as sign-magnitude {re, im}.
//   idx   : twiddle index k
//   tw_re : real part of W8^k
//   tw_im : imaginary part of W8^k
module tw_rom
    import fft_pkg::*;
(
    input  logic [1:0]        idx,
    output logic [N_DATA-1:0] tw_re,
    output logic [N_DATA-1:0] tw_im
);
    assign {tw_re, tw_im} = W8_TW[idx];
endmodule

// File: rtl/fft_cmul_ctrl.sv
// Sequencing controller for the shared complex multiplier in the butterfly.
// Accepts a sample + twiddle index, drives the multiplier operands and
// negate flags, pulses mul_en once, waits out the multiplier latency and
// returns the captured RE/IM with the request tag.
//   Clock, Rst      : clock, synchronous active-high reset
//   bus             : request/result channels (slave side)
//   mul_en          : single-cycle start pulse to the multiplier
//   REb/REB, IMb/IMB: sample real/imag operands
//   REw/REW, IMw/IMW: twiddle real/imag operands
//   nMUL1..nMUL4    : negate flags for the AC, BD, AD, BC products
//   RE, IM          : multiplier results
//   busy            : high in every state except IDLE
//   state_dbg       : current FSM state
module fft_cmul_ctrl
    import fft_pkg::*;
(
    input  logic              Clock,
    input  logic              Rst,
    fft_cmul_ctrl_if.slave    bus,
    output logic              mul_en,
    output logic [N_DATA-1:0] REb,
    output logic [N_DATA-1:0] REB,
    output logic [N_DATA-1:0] IMb,
    output logic [N_DATA-1:0] IMB,
    output logic [N_DATA-1:0] REw,
    output logic [N_DATA-1:0] REW,
    output logic [N_DATA-1:0] IMw,
    output logic [N_DATA-1:0] IMW,
    output logic              nMUL1,
    output logic              nMUL2,
    output logic              nMUL3,
    output logic              nMUL4,
    input  logic [N_DATA-1:0] RE,
    input  logic [N_DATA-1:0] IM,
    output logic              busy,
    output cmul_state_t       state_dbg
);

    logic [N_DATA-1:0] rom_re, rom_im;

    tw_rom u_tw_rom (
        .idx   (bus.req_tw),
        .tw_re (rom_re),
        .tw_im (rom_im)
    );

    cmul_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mul_en_q, mul_en_d;
    logic [N_DATA-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [3:0]        nmul_q, nmul_d;   // {nMUL4, nMUL3, nMUL2, nMUL1}
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              res_valid_q, res_valid_d;
    logic [N_DATA-1:0] res_re_q, res_re_d, res_im_q, res_im_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_en_d    = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        nmul_d      = nmul_q;
        tag_d       = tag_q;
        res_valid_d = res_valid_q;
        res_re_d    = res_re_q;
        res_im_d    = res_im_q;
        res_tag_d   = res_tag_q;

        case (state_q)
            // Let a multiplier op that was in flight before reset run out.
            ST_DRAIN: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            // Operands are loaded here so they are already stable while
            // mul_en is high and stay untouched until the next accept.
            ST_IDLE: begin
                if (bus.req_valid) begin
                    a_d      = bus.req_re;
                    b_d      = bus.req_im;
                    c_d      = rom_re;
                    d_d      = rom_im;
                    nmul_d   = {bus.req_im[N_DATA-1] ^ rom_re[N_DATA-1],
                                bus.req_re[N_DATA-1] ^ rom_im[N_DATA-1],
                                bus.req_im[N_DATA-1] ^ rom_im[N_DATA-1],
                                bus.req_re[N_DATA-1] ^ rom_re[N_DATA-1]};
                    tag_d    = bus.req_tag;
                    mul_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(MUL_LAT - 1);
                state_d = ST_WAIT;
            end
            // Counter hits zero exactly MUL_LAT edges after mul_en was sampled.
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    res_re_d    = RE;
                    res_im_d    = IM;
                    res_tag_d   = tag_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = CNT_W'(MUL_LAT);
                state_d = ST_DRAIN;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q     <= ST_DRAIN;
            cnt_q       <= CNT_W'(MUL_LAT);
            mul_en_q    <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            nmul_q      <= '0;
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_re_q    <= '0;
            res_im_q    <= '0;
            res_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_en_q    <= mul_en_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            nmul_q      <= nmul_d;
            tag_q       <= tag_d;
            res_valid_q <= res_valid_d;
            res_re_q    <= res_re_d;
            res_im_q    <= res_im_d;
            res_tag_q   <= res_tag_d;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign state_dbg     = state_q;

    assign bus.res_valid = res_valid_q;
    assign bus.res_re    = res_re_q;
    assign bus.res_im    = res_im_q;
    assign bus.res_tag   = res_tag_q;

    assign mul_en = mul_en_q;
    assign REb    = a_q;
    assign REB    = a_q;
    assign IMb    = b_q;
    assign IMB    = b_q;
    assign REw    = c_q;
    assign REW    = c_q;
    assign IMw    = d_q;
    assign IMW    = d_q;
    assign nMUL1  = nmul_q[0];
    assign nMUL2  = nmul_q[1];
    assign nMUL3  = nmul_q[2];
    assign nMUL4  = nmul_q[3];

endmodule

// File: tb/tb_fft_cmul_ctrl.sv
// Bench for fft_cmul_ctrl: a cycle-timeline model of the controller, a
// behavioural complex multiplier, directed scenarios with literal results.
module tb_fft_cmul_ctrl;
    import fft_pkg::*;

    localparam int W = 2*N_DATA + TAG_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_cmul_ctrl_if #(.N(N_DATA), .TW(TAG_W)) bus ();

    logic              mul_en, busy;
    logic [N_DATA-1:0] REb, REB, IMb, IMB, REw, REW, IMw, IMW;
    logic              nMUL1, nMUL2, nMUL3, nMUL4;
    logic [N_DATA-1:0] re_in = '0;
    logic [N_DATA-1:0] im_in = '0;
    cmul_state_t       state_dbg;

    fft_cmul_ctrl dut (
        .Clock(clk), .Rst(rst), .bus(bus),
        .mul_en(mul_en),
        .REb(REb), .REB(REB), .IMb(IMb), .IMB(IMB),
        .REw(REw), .REW(REW), .IMw(IMw), .IMW(IMW),
        .nMUL1(nMUL1), .nMUL2(nMUL2), .nMUL3(nMUL3), .nMUL4(nMUL4),
        .RE(re_in), .IM(im_in),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- arithmetic model ----------------
    logic [7:0] tb_tw_re [4] = '{8'h7F, 8'h5B, 8'h00, 8'hDB};
    logic [7:0] tb_tw_im [4] = '{8'h00, 8'hDB, 8'hFF, 8'hDB};

    function automatic int pmul(input logic [7:0] x, input logic [7:0] y);
        int m;
        m = (int'(x[6:0]) * int'(y[6:0])) >>> 7;
        return (x[7] ^ y[7]) ? -m : m;
    endfunction

    function automatic logic [7:0] i2sm(input int v);
        int c;
        c = v;
        if (c > 127)  c = 127;
        if (c < -127) c = -127;
        return (c < 0) ? {1'b1, 7'(-c)} : {1'b0, 7'(c)};
    endfunction

    // (a + jb)(c + jd) with per-product truncation
    function automatic logic [15:0] cmul(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c, input logic [7:0] d);
        return {i2sm(pmul(a, c) - pmul(b, d)), i2sm(pmul(a, d) + pmul(b, c))};
    endfunction

    // ---------------- behavioural multiplier ----------------
    // Output is garbage until MUL_LAT-1 edges after mul_en is sampled, then
    // becomes stable one cycle before the controller should capture it.
    int          mcnt = 0;
    bit          mres = 1'b0;
    logic [15:0] mtgt = '0;

    always @(posedge clk) begin
        if (mul_en === 1'b1) begin
            mtgt = cmul(REb, IMb, REw, IMw);
            mcnt = MUL_LAT - 1;
            mres = 1'b0;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) mres = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (mres) {re_in, im_in} = mtgt;
        else begin re_in = 8'h55; im_in = 8'hAA; end
    end

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    logic [W-1:0] exp_q[$];
    int           cyc        = 0;
    bit           in_flight  = 1'b0;
    int           acc_cyc    = 0;
    int           ready_from = 1 << 30;
    bit           rst_zero   = 1'b0;
    logic [7:0]   ea, eb, ec, ed;
    logic [3:0]   ef;

    // Timeline model: ready after drain or handoff, mul_en the cycle after
    // accept, result MUL_LAT+1 edges after accept until consumed.
    always @(posedge clk) begin : model_p
        int          e;
        logic [15:0] r;
        e = cyc + 1;
        if (rst) begin
            in_flight  = 1'b0;
            exp_q.delete();
            ready_from = e + MUL_LAT + 1;
            rst_zero   = 1'b1;
        end else if (!in_flight && cyc >= ready_from && bus.req_valid) begin
            in_flight = 1'b1;
            acc_cyc   = e;
            rst_zero  = 1'b0;
            ea = bus.req_re;
            eb = bus.req_im;
            ec = tb_tw_re[bus.req_tw];
            ed = tb_tw_im[bus.req_tw];
            ef = {eb[7] ^ ec[7], ea[7] ^ ed[7], eb[7] ^ ed[7], ea[7] ^ ec[7]};
            r  = cmul(ea, eb, ec, ed);
            exp_q.push_back({r, bus.req_tag});
        end else if (in_flight && cyc >= acc_cyc + MUL_LAT + 1 && bus.res_ready) begin
            exp_q.delete(0);
            in_flight  = 1'b0;
            ready_from = e;
        end
        cyc = e;
    end

    always @(negedge clk) begin : cmp_p
        bit           er, em, ev;
        logic [7:0]   xa, xb, xc, xd;
        logic [3:0]   xf;
        logic [W-1:0] h;
        if (cyc > 0) begin
            er = !in_flight && cyc >= ready_from;
            em = in_flight && cyc == acc_cyc;
            ev = in_flight && cyc >= acc_cyc + MUL_LAT + 1;
            chk("req_ready", 32'(bus.req_ready), 32'(er));
            chk("busy",      32'(busy),          32'(!er));
            chk("mul_en",    32'(mul_en),        32'(em));
            chk("res_valid", 32'(bus.res_valid), 32'(ev));
            if (in_flight || rst_zero) begin
                xa = rst_zero ? 8'h00 : ea;
                xb = rst_zero ? 8'h00 : eb;
                xc = rst_zero ? 8'h00 : ec;
                xd = rst_zero ? 8'h00 : ed;
                xf = rst_zero ? 4'h0  : ef;
                chk("REb", 32'(REb), 32'(xa)); chk("REB", 32'(REB), 32'(xa));
                chk("IMb", 32'(IMb), 32'(xb)); chk("IMB", 32'(IMB), 32'(xb));
                chk("REw", 32'(REw), 32'(xc)); chk("REW", 32'(REW), 32'(xc));
                chk("IMw", 32'(IMw), 32'(xd)); chk("IMW", 32'(IMW), 32'(xd));
                chk("flags", 32'({nMUL4, nMUL3, nMUL2, nMUL1}), 32'(xf));
            end
            if (ev) begin
                h = exp_q[0];
                chk("res_re",  32'(bus.res_re),  32'(h[W-1 -: 8]));
                chk("res_im",  32'(bus.res_im),  32'(h[TAG_W +: 8]));
                chk("res_tag", 32'(bus.res_tag), 32'(h[TAG_W-1:0]));
            end else if (rst_zero) begin
                chk("res_zero", 32'({bus.res_re, bus.res_im, bus.res_tag}), 32'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] re, input logic [7:0] im,
                        input logic [1:0] tw, input logic [2:0] tag);
        bit ok;
        @(negedge clk);
        bus.req_re = re; bus.req_im = im; bus.req_tw = tw; bus.req_tag = tag;
        bus.req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (bus.req_ready === 1'b1) begin ok = 1'b1; break; end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("accept", 32'(ok), 32'(1));
    endtask

    // edges until res_valid rises (bounded)
    task automatic wait_res(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); n++; #1;
            if (bus.res_valid === 1'b1) break;
        end
    endtask

    // edges after reset release until req_ready rises (bounded)
    task automatic drain_len(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); n++; #1;
            if (bus.req_ready === 1'b1) break;
        end
    endtask

    task automatic handoff();
        @(negedge clk); bus.res_ready = 1'b1;
        @(negedge clk); bus.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    logic [20:0] vec [3] = '{
        {8'h7F, 8'h7F, 2'd1, 3'd4},
        {8'h85, 8'hFF, 2'd3, 3'd0},
        {8'h00, 8'h80, 2'd2, 3'd2}
    };

    initial begin
        int n;
        logic [20:0] v;
        bus.req_valid = 1'b0; bus.req_re = '0; bus.req_im = '0;
        bus.req_tw = '0; bus.req_tag = '0; bus.res_ready = 1'b0;

        // Reset drain with a request already pending, then k=0 identity
        bus.req_re = 8'h40; bus.req_im = 8'h00; bus.req_tw = 2'd0; bus.req_tag = 3'd5;
        bus.req_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drain_len(n);
        chk("drain_len", 32'(n), 32'd14);
        send(8'h40, 8'h00, 2'd0, 3'd5);
        chk("k0_mul_en", 32'(mul_en), 32'd1);
        chk("k0_ops", 32'({REb, IMb, REw, IMw}), 32'h4000_7F00);
        chk("k0_flags", 32'({nMUL4, nMUL3, nMUL2, nMUL1}), 32'd0);
        wait_res(n);
        chk("k0_latency", 32'(n), 32'd14);
        chk("k0_res", 32'({bus.res_re, bus.res_im, bus.res_tag}), 32'({8'h3F, 8'h00, 3'd5}));
        handoff();

        // k=2 sign flags
        send(8'h40, 8'h00, 2'd2, 3'd2);
        chk("k2_IMw", 32'(IMw), 32'hFF);
        chk("k2_flags", 32'({nMUL4, nMUL3, nMUL2, nMUL1}), 32'b0110);
        wait_res(n);
        chk("k2_res", 32'({bus.res_re, bus.res_im, bus.res_tag}), 32'({8'h00, 8'hBF, 3'd2}));
        handoff();

        // Negative sample, k=3
        send(8'hC0, 8'h40, 2'd3, 3'd3);
        chk("k3_flags", 32'({nMUL4, nMUL3, nMUL2, nMUL1}), 32'b1010);
        wait_res(n);
        chk("k3_res", 32'({bus.res_re, bus.res_im, bus.res_tag}), 32'({8'h5A, 8'h00, 3'd3}));
        handoff();

        // Backpressure: 20 cycles stalled in DONE, then release
        send(8'h20, 8'h10, 2'd1, 3'd6);
        wait_res(n);
        chk("bp_latency", 32'(n), 32'd14);
        repeat (20) @(negedge clk);
        chk("bp_still_valid", 32'(bus.res_valid), 32'd1);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_after", 32'(bus.req_ready), 32'd1);
        @(negedge clk); bus.res_ready = 1'b0;

        // Reset mid-WAIT: op abandoned, drain repeats, next op completes
        send(8'h30, 8'hB0, 2'd1, 3'd7);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_no_valid", 32'(bus.res_valid), 32'd0);
        drain_len(n);
        chk("rst_drain_len", 32'(n), 32'd14);
        send(8'h40, 8'h00, 2'd0, 3'd1);
        wait_res(n);
        chk("rst_next_res", 32'({bus.res_re, bus.res_im, bus.res_tag}), 32'({8'h3F, 8'h00, 3'd1}));
        handoff();

        // A few more vectors checked by the model only
        for (int i = 0; i < 3; i++) begin
            v = vec[i];
            send(v[20:13], v[12:5], v[4:3], v[2:0]);
            wait_res(n);
            chk("vec_latency", 32'(n), 32'd14);
            handoff();
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_cmul_ctrl.md
# fft_cmul_ctrl

Sequencing controller for the shared complex multiplier (`mul`) in the FFT butterfly path. It accepts one complex sample plus a twiddle index per request over a valid/ready handshake. It looks up the twiddle, drives the multiplier operand and sign-flag ports, and issues a single-cycle `mul_en` pulse. It then waits out the multiplier's fixed latency, captures RE/IM and returns them with the request tag over a second valid/ready handshake.

## Interface
- `n`, 8: data width; sign-magnitude (bit n-1 sign, bits n-2:0 Q7 magnitude)
- `LAT`, 13: edges from `mul_en` sampled high until multiplier RE and IM are both stable
- `TAG_W`, 3: request tag width

- `Clock`  in  1  system clock
- `Rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept
- `req_re`, `req_im`  in  n  sample, sign-magnitude
- `req_tw`  in  2  twiddle index k of W8^k
- `req_tag`  in  TAG_W  opaque tag
- `mul_en`  out  1  start pulse to multiplier
- `REb`, `REB`, `IMb`, `IMB`  out  n  sample real/imag operands
- `REw`, `REW`, `IMw`, `IMW`  out  n  twiddle real/imag operands
- `nMUL1`..`nMUL4`  out  1  negate flags for AC, BD, AD, BC products
- `RE`, `IM`  in  n  multiplier results
- `res_valid`  out  1  result present
- `res_ready`  in  1  consumer accepts
- `res_re`, `res_im`  out  n  captured RE/IM
- `res_tag`  out  TAG_W  tag of the request
- `busy`  out  1  high in every state except IDLE

## Operation
- States: DRAIN → IDLE → ISSUE → WAIT → DONE → IDLE.
- **DRAIN**
  - Entered on reset.
  - Lets a multiplier op that was in flight complete.
  - Holds for LAT+1 cycles, then goes to IDLE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch sample, twiddle ROM entry and tag into operand registers; go to ISSUE.
- **ISSUE**
  - `mul_en`=1 for exactly this one cycle; load the wait counter with LAT-1.
  - Go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - At zero: register `RE`→`res_re`, `IM`→`res_im`; go to DONE.
- **DONE**
  - `res_valid`=1; all `res_*` held stable.
  - On `res_ready`: go to IDLE.
- Operand mapping:
  - `REb`=`REB`=sample re; `IMb`=`IMB`=sample im.
  - `REw`=`REW`=twiddle re; `IMw`=`IMW`=twiddle im.
  - All operands stay constant from ISSUE through DONE, because the multiplier samples them at different internal steps.
- Flags (XOR of operand sign bits):
  - `nMUL1`=sA^sC, `nMUL2`=sB^sD, `nMUL3`=sA^sD, `nMUL4`=sB^sC.
  - A=sample re, B=sample im, C=twiddle re, D=twiddle im.
  - Registered with the operands.
- Twiddle ROM, W8^k as {re, im}:
  - k=0: {0x7F, 0x00}
  - k=1: {0x5B, 0xDB}
  - k=2: {0x00, 0xFF}
  - k=3: {0xDB, 0xDB}
- `mul_en` is low at least LAT cycles between pulses, so the multiplier's rising-edge detector always sees a fresh edge.

## Timing
- Reset values: `req_ready`=0, `mul_en`=0, `res_valid`=0, `busy`=1 (DRAIN). All operands, flags and `res_*` are 0.
- Request accepted at edge E:
  - `mul_en` is high in cycle E..E+1 and sampled at edge E+1.
  - Results are captured at edge E+1+LAT (E+14); `res_valid` is high from then.
- Throughput: one op per LAT+3 cycles when `res_ready` is held high.
- `req_ready` is combinational from state only (IDLE). It never depends on `req_valid`.
- `res_ready` low in DONE stalls indefinitely with outputs frozen.
- There is no accept in the same cycle as a result handoff; IDLE always separates them.
- `Rst` mid-operation:
  - Abandons the op; no result is emitted.
  - Re-enters DRAIN, so the multiplier (which has its own reset) finishes before the next `mul_en`.
- `req_valid` during a non-IDLE state is ignored; the requester must hold it.

## Structure
- Shared package `fft_pkg`:
  - `cmul_state_t` enum.
  - Twiddle ROM constant array `W8_TW[4]`.
  - Width constants `N_DATA`, `MUL_LAT`.
- One natural sub-module: `tw_rom`, combinational index→{re, im} lookup over `W8_TW`.
- Everything else is flat in `fft_cmul_ctrl`.

## Test plan
- **Reset drain:** pulse `Rst`, hold `req_valid`.
  - `req_ready` stays 0 for LAT+1 cycles after reset release, then rises.
- **k=0 identity:** sample {0x40, 0x00}, k=0, tag 5, bench-model multiplier.
  - One `mul_en` pulse; operands 0x40/0x00/0x7F/0x00; all flags 0.
  - `res_valid` 14 edges after accept, with `res_re`=0x3F, `res_tag`=5.
- **k=2 sign flags:** sample {0x40, 0x00}, k=2.
  - `IMw`=0xFF, `nMUL3`=1, `nMUL2`=1, `nMUL1`=0, `nMUL4`=0.
  - Result equals the model's RE/IM.
- **Negative sample, k=3:** sample {0xC0, 0x40}.
  - Flags: `nMUL1`=0, `nMUL2`=1, `nMUL3`=0, `nMUL4`=1.
- **Backpressure:** `res_ready`=0 for 20 cycles in DONE.
  - `res_*` stable, no second `mul_en`, `req_ready`=0.
  - Release → IDLE next cycle.
- **Reset mid-WAIT:** `Rst` at accept+6.
  - No `res_valid`; DRAIN repeats; the next request completes correctly.
